// File: rtl/gcd_lcm_post_if.sv
// rtl/gcd_lcm_post_if.sv - operand, GCD and LCM handshake bundle for gcd_lcm_post
interface gcd_lcm_post_if #(
    parameter int W = 16
);
    logic [2*W-1:0] op_msg;
    logic           op_val;
    logic           op_rdy;
    logic [W-1:0]   gcd_msg;
    logic           gcd_val;
    logic           gcd_rdy;
    logic [2*W-1:0] lcm_msg;
    logic           lcm_val;
    logic           lcm_rdy;
    logic           lcm_err;

    modport master (
        output op_msg, op_val, gcd_msg, gcd_val, lcm_rdy,
        input  op_rdy, gcd_rdy, lcm_msg, lcm_val, lcm_err
    );

    modport slave (
        input  op_msg, op_val, gcd_msg, gcd_val, lcm_rdy,
        output op_rdy, gcd_rdy, lcm_msg, lcm_val, lcm_err
    );
endinterface

// File: rtl/gcd_lcm_post.sv
// rtl/gcd_lcm_post.sv - LCM stage after GcdUnit: operand FIFO, restoring divide, multiply
// Optional macro LCM_CHECK_EN: sticky lcm_err when the GCD does not divide a.
module gcd_lcm_post #(
    parameter int OP_DEPTH = 4,
    parameter int W        = 16
) (
    input  logic           clk,
    input  logic           reset,
    gcd_lcm_post_if.slave  bus
);
    localparam int AW = $clog2(OP_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    state_t         state_q;
    logic [2*W-1:0] mem_q [OP_DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic           op_rdy_q, gcd_rdy_q, lcm_val_q;
    logic [2*W-1:0] lcm_msg_q;
    logic [W-1:0]   g_q, b_q, rem_q, dvd_q;
    logic [CW-1:0]  cnt_q;

    logic           push, pop, empty_d, full_d, take;
    logic [W-1:0]   head_a, head_b, rem_d, dvd_d;
    logic [W:0]     shift, diff;
    logic [2*W-1:0] prod;

    assign push     = bus.op_val && op_rdy_q;
    assign pop      = bus.gcd_val && gcd_rdy_q;
    assign wr_ptr_d = wr_ptr_q + PW'(push);
    assign rd_ptr_d = rd_ptr_q + PW'(pop);
    assign empty_d  = (wr_ptr_d == rd_ptr_d);
    assign full_d   = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);

    assign head_a = mem_q[rd_ptr_q[AW-1:0]][2*W-1:W];
    assign head_b = mem_q[rd_ptr_q[AW-1:0]][W-1:0];

    // rem < g always holds, so the shifted remainder fits in W+1 bits
    assign shift = {rem_q, dvd_q[W-1]};
    assign diff  = shift - {1'b0, g_q};
    assign take  = (shift >= {1'b0, g_q});
    assign rem_d = take ? diff[W-1:0] : shift[W-1:0];
    assign dvd_d = {dvd_q[W-2:0], take};
    assign prod  = (2*W)'(dvd_d) * (2*W)'(b_q);

`ifdef LCM_CHECK_EN
    logic lcm_err_q;
    assign bus.lcm_err = lcm_err_q;
`else
    assign bus.lcm_err = 1'b0;
`endif

    assign bus.op_rdy  = op_rdy_q;
    assign bus.gcd_rdy = gcd_rdy_q;
    assign bus.lcm_val = lcm_val_q;
    assign bus.lcm_msg = lcm_msg_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.op_msg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            op_rdy_q  <= 1'b0;
            gcd_rdy_q <= 1'b0;
            lcm_val_q <= 1'b0;
            lcm_msg_q <= '0;
            g_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            cnt_q     <= '0;
`ifdef LCM_CHECK_EN
            lcm_err_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            op_rdy_q <= !full_d;
            case (state_q)
                S_IDLE: begin
                    gcd_rdy_q <= !empty_d && !pop;
                    if (pop) begin
                        g_q <= bus.gcd_msg;
                        b_q <= head_b;
                        if (head_a == '0 || head_b == '0 || bus.gcd_msg == '0) begin
                            lcm_msg_q <= '0;
                            state_q   <= S_DONE;
                        end else begin
                            rem_q   <= '0;
                            dvd_q   <= head_a;
                            cnt_q   <= CW'(W - 1);
                            state_q <= S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    rem_q <= rem_d;
                    dvd_q <= dvd_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        lcm_msg_q <= prod;
                        state_q   <= S_DONE;
`ifdef LCM_CHECK_EN
                        if (rem_d != '0) begin
                            lcm_err_q <= 1'b1;
                        end
`endif
                    end
                end
                S_DONE: begin
                    // lcm_val rises one cycle after entering DONE
                    if (!lcm_val_q) begin
                        lcm_val_q <= 1'b1;
                    end else if (bus.lcm_rdy) begin
                        lcm_val_q <= 1'b0;
                        gcd_rdy_q <= !empty_d;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
